tdm_demux4: RTL and testbench
=============================

Name: tdm_demux4

Overview:
- Inverse of the team's 4:1 select mux: takes a time-multiplexed sample stream and redistributes it to four channels a, b, c, d.
- Channel index follows the mux encoding {s1,s0}: a=00, b=01, c=10, d=11.
- Sits on the receive side of a serialised link. It tracks frame alignment from a start-of-frame marker and presents each complete 4-sample frame on four registered outputs at the same time.

Parameters:
- W, 1, width of each sample and each channel output.
- SOF_STRICT, 1: when 1, every frame must start with in_sof; when 0, channel 0 may be accepted without in_sof once in RUN.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  sample present on in_data this cycle.
- in_data  input  W  sample.
- in_sof  input  1  qualifies in_data as channel a (index 00); meaningful only when in_valid=1.
- out_a  output  W  channel 00 of the last complete frame.
- out_b  output  W  channel 01 of the last complete frame.
- out_c  output  W  channel 10 of the last complete frame.
- out_d  output  W  channel 11 of the last complete frame.
- frame_valid  output  1  one-cycle pulse: out_a..out_d just updated.
- s1, s0  output  1 each  index of the next expected channel.
- locked  output  1  high while in RUN.
- sync_err  output  1  one-cycle pulse on an alignment violation.
- frame_cnt  output  8  count of completed frames; wraps 255->0.

Behaviour:
- Reset (asynchronous, any time including mid-frame):
  - state=HUNT, {s1,s0}=00.
  - out_a..out_d=0, frame_valid=0, sync_err=0, locked=0, frame_cnt=0.
  - Staging registers cleared; any partial frame is discarded.
- Sample acceptance: a sample is accepted on a rising clk edge with in_valid=1. With in_valid=0, all state holds and the pulse outputs deassert.
- HUNT state:
  - Accepted samples with in_sof=0 are dropped with no error.
  - An accepted sample with in_sof=1 is staged as channel a; {s1,s0}->01, state->RUN, locked=1 from the next cycle.
- RUN state, accepted sample with index {s1,s0}:
  - Sample goes into the staging register for that index; index increments mod 4.
  - When index 11 is accepted, out_a..out_d load from staging (index 11 taken directly from in_data) on that same edge. frame_valid=1 for exactly that following cycle and frame_cnt increments.
  - Latency: the 4th sample edge produces outputs plus frame_valid in the next cycle.
  - in_sof=1 at index 00: normal frame start.
  - in_sof=1 at index 01/10/11 (early SOF):
    - sync_err pulses.
    - Partial frame discarded; the current sample is staged as channel a; index->01.
    - Stays in RUN; no frame_valid; frame_cnt unchanged.
  - in_sof=0 at index 00 with SOF_STRICT=1:
    - sync_err pulses; sample dropped; state->HUNT, locked=0, index->00.
  - in_sof=0 at index 00 with SOF_STRICT=0: accepted as channel a.
- Output holding: out_a..out_d change only on frame completion or reset. Errors never disturb them.
- Back-to-back frames: 8 consecutive valid cycles give two frame_valid pulses, 4 cycles apart, with no gap required.
- frame_cnt wrap: 255 + 1 -> 0, with no flag.

Test Plan:
- Reset then 4 valid cycles, in_sof on the first, data 1,0,1,1 (W=1) -> one cycle after the 4th: out_a=1, out_b=0, out_c=1, out_d=1, frame_valid=1 for one cycle, frame_cnt=1, locked=1, {s1,s0}=00.
- In HUNT, 3 valid samples with in_sof=0, then an SOF frame 0,1,1,0 -> first three ignored, sync_err never asserted; outputs 0,1,1,0 after the frame; frame_cnt=1.
- Locked, send samples 1,1 then in_sof=1 with data 0, followed by 0,1,0 -> sync_err one pulse on the early SOF; next frame_valid shows out_a..out_d=0,0,1,0; prior outputs held until then.
- SOF_STRICT=1, locked, frame start with in_sof=0 -> sync_err pulse, locked=0, no output change; SOF_STRICT=0 same stimulus -> frame accepted normally.
- Interleave in_valid=0 bubbles between the samples of one frame -> same outputs as gap-free; frame_valid only after the 4th valid sample.
- Assert rst after 2 samples of a frame, then send a full frame -> all outputs 0 during reset; the new frame completes correctly; 256 frames total -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/tdm_demux4.sv
// tdm_demux4 -- receive-side demultiplexer for a 4-channel TDM sample stream.
//
// Tracks frame alignment from a start-of-frame marker, stages channels
// a..c, and presents each complete 4-sample frame on four registered
// outputs simultaneously. Channel index follows the {s1,s0} mux encoding:
// a=00, b=01, c=10, d=11.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   in_valid     sample present on in_data this cycle
//   in_data      sample (W bits)
//   in_sof       marks in_data as channel a (only meaningful with in_valid)
//   out_a..out_d channels 00..11 of the last complete frame
//   frame_valid  one-cycle pulse: out_a..out_d just updated
//   s1, s0       index of the next expected channel
//   locked       high while aligned (RUN)
//   sync_err     one-cycle pulse on an alignment violation
//   frame_cnt    completed frame count, wraps 255 -> 0
module tdm_demux4 #(
    parameter int W          = 1,
    parameter bit SOF_STRICT = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         in_sof,
    output logic [W-1:0] out_a,
    output logic [W-1:0] out_b,
    output logic [W-1:0] out_c,
    output logic [W-1:0] out_d,
    output logic         frame_valid,
    output logic         s1,
    output logic         s0,
    output logic         locked,
    output logic         sync_err,
    output logic [7:0]   frame_cnt
);

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t       state, state_nxt;
    logic [1:0]   idx, idx_nxt;
    logic [W-1:0] stg_a, stg_b, stg_c;
    logic [W-1:0] stg_a_nxt, stg_b_nxt, stg_c_nxt;
    logic [W-1:0] out_a_nxt, out_b_nxt, out_c_nxt, out_d_nxt;
    logic         frame_valid_nxt, sync_err_nxt;
    logic [7:0]   frame_cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= HUNT;
            idx         <= 2'b00;
            stg_a       <= '0;
            stg_b       <= '0;
            stg_c       <= '0;
            out_a       <= '0;
            out_b       <= '0;
            out_c       <= '0;
            out_d       <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            stg_a       <= stg_a_nxt;
            stg_b       <= stg_b_nxt;
            stg_c       <= stg_c_nxt;
            out_a       <= out_a_nxt;
            out_b       <= out_b_nxt;
            out_c       <= out_c_nxt;
            out_d       <= out_d_nxt;
            frame_valid <= frame_valid_nxt;
            sync_err    <= sync_err_nxt;
            frame_cnt   <= frame_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        idx_nxt         = idx;
        stg_a_nxt       = stg_a;
        stg_b_nxt       = stg_b;
        stg_c_nxt       = stg_c;
        out_a_nxt       = out_a;
        out_b_nxt       = out_b;
        out_c_nxt       = out_c;
        out_d_nxt       = out_d;
        frame_valid_nxt = 1'b0;
        sync_err_nxt    = 1'b0;
        frame_cnt_nxt   = frame_cnt;

        if (in_valid) begin
            unique case (state)
                HUNT: begin
                    // Non-SOF samples are silently dropped while hunting.
                    if (in_sof) begin
                        stg_a_nxt = in_data;
                        idx_nxt   = 2'b01;
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (idx == 2'b00) begin
                        if (in_sof || !SOF_STRICT) begin
                            stg_a_nxt = in_data;
                            idx_nxt   = 2'b01;
                        end else begin
                            sync_err_nxt = 1'b1;
                            state_nxt    = HUNT;
                            idx_nxt      = 2'b00;
                        end
                    end else if (in_sof) begin
                        // Early SOF: drop the partial frame and realign on
                        // this sample without leaving RUN.
                        sync_err_nxt = 1'b1;
                        stg_a_nxt    = in_data;
                        stg_b_nxt    = '0;
                        stg_c_nxt    = '0;
                        idx_nxt      = 2'b01;
                    end else begin
                        unique case (idx)
                            2'b01: stg_b_nxt = in_data;
                            2'b10: stg_c_nxt = in_data;
                            default: begin
                                // Channel d bypasses staging so the whole
                                // frame lands on the same edge.
                                out_a_nxt       = stg_a;
                                out_b_nxt       = stg_b;
                                out_c_nxt       = stg_c;
                                out_d_nxt       = in_data;
                                frame_valid_nxt = 1'b1;
                                frame_cnt_nxt   = frame_cnt + 8'd1;
                            end
                        endcase
                        idx_nxt = idx + 2'd1;
                    end
                end
                default: begin
                    state_nxt = HUNT;
                    idx_nxt   = 2'b00;
                end
            endcase
        end
    end

    assign s1     = idx[1];
    assign s0     = idx[0];
    assign locked = (state == RUN);

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4 -- self-checking bench for tdm_demux4.
// Two instances share one stimulus stream: u_strict (SOF_STRICT=1) and
// u_lax (SOF_STRICT=0). Each is compared every cycle against a frame-level
// reference model that tracks alignment as "samples collected so far".
module tb_tdm_demux4;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_sof;
    logic [W-1:0] in_data;

    logic [W-1:0] oa [2];
    logic [W-1:0] ob [2];
    logic [W-1:0] oc [2];
    logic [W-1:0] od [2];
    logic         fv [2];
    logic         hs1 [2];
    logic         hs0 [2];
    logic         lk [2];
    logic         se [2];
    logic [7:0]   fc [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tdm_demux4 #(.W(W), .SOF_STRICT(1'b1)) u_strict (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
        .out_a(oa[0]), .out_b(ob[0]), .out_c(oc[0]), .out_d(od[0]),
        .frame_valid(fv[0]), .s1(hs1[0]), .s0(hs0[0]), .locked(lk[0]),
        .sync_err(se[0]), .frame_cnt(fc[0])
    );

    tdm_demux4 #(.W(W), .SOF_STRICT(1'b0)) u_lax (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
        .out_a(oa[1]), .out_b(ob[1]), .out_c(oc[1]), .out_d(od[1]),
        .frame_valid(fv[1]), .s1(hs1[1]), .s0(hs0[1]), .locked(lk[1]),
        .sync_err(se[1]), .frame_cnt(fc[1])
    );

    // Reference model: per instance, whether aligned, how many samples of
    // the current frame have been collected, and the last published frame.
    bit           m_locked [2];
    int           m_n      [2];
    logic [W-1:0] m_buf    [2][4];
    logic [W-1:0] m_out    [2][4];
    bit           m_fv     [2];
    bit           m_err    [2];
    int           m_cnt    [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_locked[k] = 1'b0;
            m_n[k]      = 0;
            m_fv[k]     = 1'b0;
            m_err[k]    = 1'b0;
            m_cnt[k]    = 0;
            for (int j = 0; j < 4; j++) begin
                m_buf[k][j] = '0;
                m_out[k][j] = '0;
            end
        end
    endfunction

    function automatic void model_step(int k, bit strict, bit v, bit sof, logic [W-1:0] d);
        m_fv[k]  = 1'b0;
        m_err[k] = 1'b0;
        if (!v) return;
        if (!m_locked[k]) begin
            if (sof) begin
                m_buf[k][0] = d;
                m_n[k]      = 1;
                m_locked[k] = 1'b1;
            end
        end else if (m_n[k] == 0) begin
            if (sof || !strict) begin
                m_buf[k][0] = d;
                m_n[k]      = 1;
            end else begin
                m_err[k]    = 1'b1;
                m_locked[k] = 1'b0;
            end
        end else if (sof) begin
            m_err[k]    = 1'b1;
            m_buf[k][0] = d;
            m_n[k]      = 1;
        end else begin
            m_buf[k][m_n[k]] = d;
            m_n[k]++;
            if (m_n[k] == 4) begin
                for (int j = 0; j < 4; j++) m_out[k][j] = m_buf[k][j];
                m_fv[k]  = 1'b1;
                m_cnt[k] = (m_cnt[k] + 1) % 256;
                m_n[k]   = 0;
            end
        end
    endfunction

    task automatic check_all(input string tag);
        for (int k = 0; k < 2; k++) begin
            string p;
            p = $sformatf("%s/u%0d", tag, k);
            check({p, ".outs"}, 32'({oa[k], ob[k], oc[k], od[k]}),
                  32'({m_out[k][0], m_out[k][1], m_out[k][2], m_out[k][3]}));
            check({p, ".frame_valid"}, 32'(fv[k]), 32'(m_fv[k]));
            check({p, ".sync_err"}, 32'(se[k]), 32'(m_err[k]));
            check({p, ".locked"}, 32'(lk[k]), 32'(m_locked[k]));
            check({p, ".index"}, 32'({hs1[k], hs0[k]}), m_locked[k] ? 32'(m_n[k]) : 32'd0);
            check({p, ".frame_cnt"}, 32'(fc[k]), 32'(m_cnt[k]));
        end
    endtask

    task automatic step(input bit v, input bit sof, input logic [W-1:0] d, input string tag);
        @(negedge clk);
        in_valid = v;
        in_sof   = sof;
        in_data  = d;
        @(posedge clk);
        model_step(0, 1'b1, v, sof, d);
        model_step(1, 1'b0, v, sof, d);
        #1;
        check_all(tag);
    endtask

    // Reset is raised between clock edges to exercise the asynchronous path.
    task automatic do_reset(input string tag);
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        #1 check_all({tag, ".async"});
        @(posedge clk);
        #1 check_all({tag, ".held"});
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic frame(input logic [W-1:0] a, b, c, d, input string tag);
        step(1'b1, 1'b1, a, tag);
        step(1'b1, 1'b0, b, tag);
        step(1'b1, 1'b0, c, tag);
        step(1'b1, 1'b0, d, tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int gpos;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = '0;
        model_reset();

        // Basic frame 1,0,1,1.
        do_reset("tp1_rst");
        frame(4'd1, 4'd0, 4'd1, 4'd1, "tp1");
        check("tp1_outs", 32'({oa[0], ob[0], oc[0], od[0]}), 32'h1011);
        check("tp1_fv", 32'(fv[0]), 32'd1);
        check("tp1_cnt", 32'(fc[0]), 32'd1);
        check("tp1_idx", 32'({hs1[0], hs0[0]}), 32'd0);
        step(1'b0, 1'b0, 4'd0, "tp1_idle");
        check("tp1_fv_pulse", 32'(fv[0]), 32'd0);

        // Non-SOF samples dropped while hunting.
        do_reset("tp2_rst");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'(i + 5), "tp2_hunt");
        frame(4'd0, 4'd1, 4'd1, 4'd0, "tp2");
        check("tp2_outs", 32'({oa[0], ob[0], oc[0], od[0]}), 32'h0110);
        check("tp2_cnt", 32'(fc[0]), 32'd1);

        // Early SOF realigns; previous outputs held until the next frame.
        step(1'b1, 1'b1, 4'd1, "tp3");
        step(1'b1, 1'b0, 4'd1, "tp3");
        step(1'b1, 1'b1, 4'd0, "tp3_early");
        check("tp3_err", 32'(se[0]), 32'd1);
        check("tp3_held", 32'({oa[0], ob[0], oc[0], od[0]}), 32'h0110);
        step(1'b1, 1'b0, 4'd0, "tp3");
        step(1'b1, 1'b0, 4'd1, "tp3");
        step(1'b1, 1'b0, 4'd0, "tp3");
        check("tp3_outs", 32'({oa[0], ob[0], oc[0], od[0]}), 32'h0010);

        // Missing SOF at frame start: strict loses lock, lax accepts.
        step(1'b1, 1'b0, 4'd5, "tp4_nosof");
        check("tp4_strict_err", 32'(se[0]), 32'd1);
        check("tp4_strict_lock", 32'(lk[0]), 32'd0);
        check("tp4_lax_err", 32'(se[1]), 32'd0);
        step(1'b1, 1'b0, 4'd6, "tp4");
        step(1'b1, 1'b0, 4'd7, "tp4");
        step(1'b1, 1'b0, 4'd8, "tp4");
        check("tp4_lax_outs", 32'({oa[1], ob[1], oc[1], od[1]}), 32'h5678);
        check("tp4_strict_outs", 32'({oa[0], ob[0], oc[0], od[0]}), 32'h0010);

        // Bubbles inside a frame.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, i == 0, 4'(i + 9), "tp5");
            for (int j = 0; j < 2; j++) step(1'b0, 1'b1, 4'hF, "tp5_bubble");
        end
        check("tp5_outs", 32'({oa[0], ob[0], oc[0], od[0]}), 32'h9ABC);

        // Randomised traffic, mostly well-formed with injected faults.
        gpos = 0;
        for (int i = 0; i < 3000; i++) begin
            bit v, sof;
            v = ($urandom_range(0, 3) != 0);
            sof = 1'b0;
            if (v) begin
                if (gpos == 0) sof = ($urandom_range(0, 9) != 0);
                else           sof = ($urandom_range(0, 19) == 0);
                gpos = sof ? 1 : (gpos + 1) % 4;
            end
            step(v, sof, 4'($urandom), "rand");
        end

        // Reset mid-frame, then 256 frames to wrap the counter.
        step(1'b1, 1'b1, 4'd3, "tp6_partial");
        step(1'b1, 1'b0, 4'd4, "tp6_partial");
        do_reset("tp6_rst");
        for (int f = 0; f < 256; f++)
            frame(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), "tp6");
        check("tp6_wrap", 32'(fc[0]), 32'd0);
        check("tp6_wrap_fv", 32'(fv[0]), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
